// File: rtl/md_unit_pkg.sv
// md_unit_pkg -- shared CPU definitions for the multiply/divide unit.
// Holds the HI/LO op encodings, the FSM state encoding, the default
// busy-cycle counts and the width of the busy-cycle counter.
package md_unit_pkg;

  // Default busy-cycle counts for the two long-latency op classes
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Width of the busy-cycle counter
  localparam int CNT_W = 16;

  // Operation encodings presented on md_unit.op
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } md_op_e;

  // FSM state encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_calc.sv
// md_calc -- combinational result arithmetic for MULT/MULTU/DIV/DIVU.
// Ports:
//   op     : operation encoding (md_op_e)
//   A, B   : rs / rt operands
//   hi_res : value destined for HI (product high word or remainder)
//   lo_res : value destined for LO (product low word or quotient)
// A zero divisor yields zero outputs; the caller suppresses the commit.
module md_calc
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic [63:0] prod_s;

  // Product / quotient / remainder selection by op
  always_comb begin
    prod_s = 64'd0;
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      OP_MULT: begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      OP_MULTU: begin
        prod_s = {32'd0, A} * {32'd0, B};
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      OP_DIV: begin
        if (B == 32'd0) begin
          hi_res = 32'd0;
          lo_res = 32'd0;
        end else if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
          // The one signed overflow case: quotient wraps to the dividend
          hi_res = 32'd0;
          lo_res = 32'h8000_0000;
        end else begin
          // Verilog signed / and % truncate toward zero; remainder follows dividend
          lo_res = 32'($signed(A) / $signed(B));
          hi_res = 32'($signed(A) % $signed(B));
        end
      end
      OP_DIVU: begin
        if (B == 32'd0) begin
          hi_res = 32'd0;
          lo_res = 32'd0;
        end else begin
          lo_res = A / B;
          hi_res = A % B;
        end
      end
      default: begin
        hi_res = 32'd0;
        lo_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit -- MIPS-style HI/LO multiply/divide unit.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   start : perform/launch op this cycle (honoured only while idle)
//   op    : 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6-7 reserved
//   A, B  : rs / rt operands, sampled only at the launching edge
//   busy  : registered, high for exactly N cycles after a MULT/DIV launch
//   HI/LO : architectural result registers
// The full result is computed at launch and parked in pending registers;
// the counter only models latency. MULT_CYCLES and DIV_CYCLES must be >= 1.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      pend_hi_r, pend_hi_s;
  logic [31:0]      pend_lo_r, pend_lo_s;
  logic             pend_wr_r, pend_wr_s;
  logic [31:0]      hi_r, hi_s;
  logic [31:0]      lo_r, lo_s;
  logic             busy_r, busy_s;
  logic [31:0]      calc_hi_s, calc_lo_s;
  md_op_e           op_s;

  assign op_s = md_op_e'(op);

  md_calc u_calc (
    .op     (op_s),
    .A      (A),
    .B      (B),
    .hi_res (calc_hi_s),
    .lo_res (calc_lo_s)
  );

  // Next-state, counter, pending-result and HI/LO update logic
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pend_hi_s = pend_hi_r;
    pend_lo_s = pend_lo_r;
    pend_wr_s = pend_wr_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (op_s)
            OP_MULT, OP_MULTU: begin
              pend_hi_s = calc_hi_s;
              pend_lo_s = calc_lo_s;
              pend_wr_s = 1'b1;
              cnt_s     = CNT_W'(MULT_CYCLES);
              state_s   = ST_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_s = calc_hi_s;
              pend_lo_s = calc_lo_s;
              // A zero divisor still runs the full latency but never commits
              pend_wr_s = (B != 32'd0);
              cnt_s     = CNT_W'(DIV_CYCLES);
              state_s   = ST_BUSY;
            end
            OP_MTHI: hi_s = A;
            OP_MTLO: lo_s = A;
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // start is deliberately not examined here
        cnt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_s = ST_IDLE;
          if (pend_wr_r) begin
            hi_s = pend_hi_r;
            lo_s = pend_lo_r;
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    busy_s = (state_s == ST_BUSY);
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pend_hi_r <= pend_hi_s;
      pend_lo_r <= pend_lo_s;
      pend_wr_r <= pend_wr_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
      busy_r    <= busy_s;
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, number of busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, number of busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  launch or perform the operation on op this cycle.
REQ-006 SHALL have port op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved.
REQ-007 SHALL have port A  input  32  rs operand, from the register-file read port 1 path.
REQ-008 SHALL have port B  input  32  rt operand, from the register-file read port 2 path.
REQ-009 SHALL have port busy  output  1  high while a MULT/DIV operation is in flight.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.

Function
REQ-012 SHALL implement two states: IDLE and BUSY.
REQ-013 In IDLE, start with op 0-3 SHALL, at the edge:
- latch the full result into pending registers;
- load the cycle counter with MULT_CYCLES or DIV_CYCLES;
- enter BUSY.
REQ-014 busy SHALL be a registered output, high for exactly N cycles after the launching edge, where N is the loaded count.
REQ-015 In BUSY, each edge SHALL decrement the counter.
REQ-016 On the edge where the counter equals 1, the block SHALL:
- copy the pending results to HI/LO;
- return to IDLE.
busy falls and the new HI/LO become visible in the same cycle.
REQ-017 MULT SHALL compute the signed 32x32 to 64-bit product, with HI=product[63:32] and LO=product[31:0].
REQ-018 MULTU SHALL compute the same split for the unsigned product.
REQ-019 DIV SHALL compute signed division with LO=quotient, rounded toward zero, and HI=remainder, taking the sign of the dividend.
REQ-020 DIVU SHALL compute the unsigned quotient into LO and the unsigned remainder into HI.
REQ-021 DIV/DIVU with B=0 SHALL run the full DIV_CYCLES and then leave HI and LO unchanged.
REQ-022 DIV with A=0x80000000 and B=0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0.
REQ-023 In IDLE, start with MTHI/MTLO SHALL write A into HI/LO at the next edge, with busy staying low and no BUSY entry.
REQ-024 start SHALL be ignored for every op while in BUSY; the counter, pending results, HI and LO are unaffected.
REQ-025 start with op 6 or 7 SHALL be ignored.
REQ-026 A and B SHALL be sampled only at the launching edge; later changes have no effect on the result.
REQ-027 HI and LO SHALL change only via REQ-016 or REQ-023.

Reset
REQ-028 Asserting reset low SHALL immediately, independent of clk:
- force state to IDLE;
- force busy=0, HI=0, LO=0;
- clear the counter and pending registers.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no HI/LO commit.
REQ-030 The first edge after reset deassertion SHALL accept a new start.

Structure
REQ-031 The op encodings, state encodings and default cycle counts SHALL reside in the shared CPU definitions package.
REQ-032 Result arithmetic MAY be factored into one combinational sub-module, md_calc (inputs op, A, B; outputs hi_res, lo_res).
REQ-033 The counter, FSM and HI/LO registers SHALL stay in md_unit.

Verification
REQ-034 MULT scenario:
- stimulus: A=0xFFFFFFFE (-2), B=3, start.
- response: busy high for exactly 5 cycles; HI=0xFFFFFFFF and LO=0xFFFFFFFA when busy falls.
REQ-035 MULTU scenario:
- stimulus: A=0xFFFFFFFF, B=0xFFFFFFFF.
- response: HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
REQ-036 DIV scenario:
- stimulus: A=-7, B=2.
- response: busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- follow-up stimulus: DIVU with B=0 after MTHI 0x1234 and MTLO 0x5678.
- follow-up response: HI/LO stay 0x1234/0x5678.
REQ-037 Start-while-busy scenario:
- stimulus: MTLO 0xDEAD and a second MULT issued while a DIV is busy.
- response: both ignored; only the DIV result commits at cycle 10.
REQ-038 Reset scenario:
- stimulus: reset driven low in cycle 3 of a MULT.
- response: busy, HI and LO read 0 before the next edge; no commit occurs afterward.
- follow-up stimulus: start MULT 6x7 on the first edge after release.
- follow-up response: LO=42.
